// File: rtl/alu_sequencer_pkg.sv
// Shared encodings for the ALU sequencer: FSM states, opcode/ext fields, ALU codes,
// branch condition codes and PSR bit layout.
package alu_sequencer_pkg;

    typedef enum logic [1:0] {
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_WRITEBACK
    } state_t;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_ADDI  = 4'd1;
    localparam logic [3:0] ALU_ADDU  = 4'd2;
    localparam logic [3:0] ALU_ADDUI = 4'd3;
    localparam logic [3:0] ALU_MUL   = 4'd4;
    localparam logic [3:0] ALU_SUB   = 4'd5;
    localparam logic [3:0] ALU_SUBI  = 4'd6;
    localparam logic [3:0] ALU_CMP   = 4'd7;
    localparam logic [3:0] ALU_CMPI  = 4'd8;
    localparam logic [3:0] ALU_AND   = 4'd9;
    localparam logic [3:0] ALU_ANDI  = 4'd10;
    localparam logic [3:0] ALU_OR    = 4'd11;
    localparam logic [3:0] ALU_ORI   = 4'd12;
    localparam logic [3:0] ALU_XOR   = 4'd13;
    localparam logic [3:0] ALU_XORI  = 4'd14;

    // Immediate-form opcodes reuse the register-form ext codes.
    localparam logic [3:0] OP_REG   = 4'b0000;
    localparam logic [3:0] OP_BCOND = 4'b1100;
    localparam logic [3:0] EXT_AND  = 4'b0001;
    localparam logic [3:0] EXT_OR   = 4'b0010;
    localparam logic [3:0] EXT_XOR  = 4'b0011;
    localparam logic [3:0] EXT_ADD  = 4'b0101;
    localparam logic [3:0] EXT_ADDU = 4'b0110;
    localparam logic [3:0] EXT_SUB  = 4'b1001;
    localparam logic [3:0] EXT_CMP  = 4'b1011;
    localparam logic [3:0] EXT_MUL  = 4'b1110;

    localparam logic [3:0] COND_EQ = 4'd0;
    localparam logic [3:0] COND_NE = 4'd1;
    localparam logic [3:0] COND_CS = 4'd2;
    localparam logic [3:0] COND_CC = 4'd3;
    localparam logic [3:0] COND_HI = 4'd4;
    localparam logic [3:0] COND_LS = 4'd5;
    localparam logic [3:0] COND_GT = 4'd6;
    localparam logic [3:0] COND_LE = 4'd7;
    localparam logic [3:0] COND_FS = 4'd8;
    localparam logic [3:0] COND_FC = 4'd9;
    localparam logic [3:0] COND_LO = 4'd10;
    localparam logic [3:0] COND_HS = 4'd11;
    localparam logic [3:0] COND_LT = 4'd12;
    localparam logic [3:0] COND_GE = 4'd13;
    localparam logic [3:0] COND_UC = 4'd14;

    // PSR layout is {L,C,Z,N,F}.
    localparam int PSR_L = 4;
    localparam int PSR_C = 3;
    localparam int PSR_Z = 2;
    localparam int PSR_N = 1;
    localparam int PSR_F = 0;

    localparam logic [4:0] MASK_CF  = 5'b01001;
    localparam logic [4:0] MASK_C   = 5'b01000;
    localparam logic [4:0] MASK_LZN = 5'b10110;

    // PSR bits that an ALU operation is allowed to overwrite.
    function automatic logic [4:0] psr_mask(input logic [3:0] code);
        logic [4:0] m;
        m = 5'b00000;
        case (code)
            ALU_ADD, ALU_ADDI, ALU_SUB, ALU_SUBI: m = MASK_CF;
            ALU_ADDU, ALU_ADDUI:                  m = MASK_C;
            ALU_CMP, ALU_CMPI:                    m = MASK_LZN;
            default:                              m = 5'b00000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational evaluation of a branch condition code against the current PSR.
module branch_cond_eval
    import alu_sequencer_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [4:0] psr,
    output logic       taken
);

    logic l, c, z, n, f;

    assign l = psr[PSR_L];
    assign c = psr[PSR_C];
    assign z = psr[PSR_Z];
    assign n = psr[PSR_N];
    assign f = psr[PSR_F];

    always_comb begin
        taken = 1'b0;
        case (cond)
            COND_EQ: taken = z;
            COND_NE: taken = !z;
            COND_CS: taken = c;
            COND_CC: taken = !c;
            COND_HI: taken = l;
            COND_LS: taken = !l;
            COND_GT: taken = n;
            COND_LE: taken = !n;
            COND_FS: taken = f;
            COND_FC: taken = !f;
            COND_LO: taken = !l && !z;
            COND_HS: taken = l || z;
            COND_LT: taken = !n && !z;
            COND_GE: taken = n || z;
            COND_UC: taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_sequencer.sv
// Fetch/decode/execute/writeback controller driving an external 16-bit ALU and register file.
module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int REGBITS = 4
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [WIDTH-1:0]   imem_addr,
    input  logic               imem_ack,
    input  logic [15:0]        imem_rdata,
    output logic [REGBITS-1:0] rf_raddr1,
    output logic [REGBITS-1:0] rf_raddr2,
    input  logic [WIDTH-1:0]   rf_rdata1,
    input  logic [WIDTH-1:0]   rf_rdata2,
    output logic [WIDTH-1:0]   alu_a,
    output logic [WIDTH-1:0]   alu_b,
    output logic [3:0]         alu_op,
    input  logic [WIDTH-1:0]   alu_result,
    input  logic [4:0]         alu_flags,
    output logic               rf_we,
    output logic [REGBITS-1:0] rf_waddr,
    output logic [WIDTH-1:0]   rf_wdata,
    output logic [4:0]         psr,
    output logic [WIDTH-1:0]   pc,
    output logic               illegal
);

    state_t           state;
    logic [15:0]      ir;
    logic [WIDTH-1:0] ex_a, ex_b, res_hold;
    logic [3:0]       ex_code;
    logic             ex_write, ex_branch;
    logic [4:0]       ex_mask, flags_hold;

    logic [3:0]       op, ext;
    logic [WIDTH-1:0] imm_sx, imm_zx;
    logic [3:0]       dec_code;
    logic [WIDTH-1:0] dec_a, dec_b;
    logic             dec_write, dec_branch, dec_illegal;
    logic             br_taken;

    assign op     = ir[15:12];
    assign ext    = ir[7:4];
    assign imm_sx = {{(WIDTH-8){ir[7]}}, ir[7:0]};
    assign imm_zx = {{(WIDTH-8){1'b0}}, ir[7:0]};

    branch_cond_eval u_cond (
        .cond  (ir[11:8]),
        .psr   (psr),
        .taken (br_taken)
    );

    // Immediate forms feed the immediate on A and Rdest on B.
    always_comb begin
        dec_code    = ALU_ADD;
        dec_a       = '0;
        dec_b       = '0;
        dec_write   = 1'b0;
        dec_branch  = 1'b0;
        dec_illegal = 1'b0;
        case (op)
            OP_REG: begin
                dec_a     = rf_rdata1;
                dec_b     = rf_rdata2;
                dec_write = 1'b1;
                case (ext)
                    EXT_AND:  dec_code = ALU_AND;
                    EXT_OR:   dec_code = ALU_OR;
                    EXT_XOR:  dec_code = ALU_XOR;
                    EXT_ADD:  dec_code = ALU_ADD;
                    EXT_ADDU: dec_code = ALU_ADDU;
                    EXT_SUB:  dec_code = ALU_SUB;
                    EXT_MUL:  dec_code = ALU_MUL;
                    EXT_CMP: begin
                        dec_code  = ALU_CMP;
                        dec_write = 1'b0;
                    end
                    default: begin
                        dec_illegal = 1'b1;
                        dec_write   = 1'b0;
                        dec_a       = '0;
                        dec_b       = '0;
                    end
                endcase
            end
            EXT_AND:  begin dec_code = ALU_ANDI;  dec_a = imm_zx; dec_b = rf_rdata1; dec_write = 1'b1; end
            EXT_OR:   begin dec_code = ALU_ORI;   dec_a = imm_zx; dec_b = rf_rdata1; dec_write = 1'b1; end
            EXT_XOR:  begin dec_code = ALU_XORI;  dec_a = imm_zx; dec_b = rf_rdata1; dec_write = 1'b1; end
            EXT_ADD:  begin dec_code = ALU_ADDI;  dec_a = imm_sx; dec_b = rf_rdata1; dec_write = 1'b1; end
            EXT_ADDU: begin dec_code = ALU_ADDUI; dec_a = imm_zx; dec_b = rf_rdata1; dec_write = 1'b1; end
            EXT_SUB:  begin dec_code = ALU_SUBI;  dec_a = imm_sx; dec_b = rf_rdata1; dec_write = 1'b1; end
            EXT_CMP:  begin dec_code = ALU_CMPI;  dec_a = imm_sx; dec_b = rf_rdata1; end
            OP_BCOND: dec_branch = 1'b1;
            default:  dec_illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_FETCH;
            pc         <= '0;
            psr        <= '0;
            ir         <= '0;
            illegal    <= 1'b0;
            ex_a       <= '0;
            ex_b       <= '0;
            ex_code    <= '0;
            ex_write   <= 1'b0;
            ex_branch  <= 1'b0;
            ex_mask    <= '0;
            res_hold   <= '0;
            flags_hold <= '0;
        end else begin
            illegal <= 1'b0;
            case (state)
                S_FETCH: begin
                    if (imem_ack) begin
                        ir    <= imem_rdata;
                        state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    ex_a      <= dec_a;
                    ex_b      <= dec_b;
                    ex_code   <= dec_code;
                    ex_write  <= dec_write;
                    ex_branch <= dec_branch;
                    // Branches and illegal words carry no ALU code, so they must not touch the PSR.
                    ex_mask   <= (dec_branch || dec_illegal) ? 5'b00000 : psr_mask(dec_code);
                    illegal   <= dec_illegal;
                    state     <= S_EXECUTE;
                end
                S_EXECUTE: begin
                    res_hold   <= alu_result;
                    flags_hold <= alu_flags;
                    state      <= S_WRITEBACK;
                end
                S_WRITEBACK: begin
                    psr   <= (psr & ~ex_mask) | (flags_hold & ex_mask);
                    pc    <= (ex_branch && br_taken) ? pc + imm_sx : pc + WIDTH'(1);
                    state <= S_FETCH;
                end
                default: state <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        imem_req  = 1'b0;
        imem_addr = '0;
        rf_raddr1 = '0;
        rf_raddr2 = '0;
        alu_a     = '0;
        alu_b     = '0;
        alu_op    = '0;
        rf_we     = 1'b0;
        rf_waddr  = '0;
        rf_wdata  = '0;
        case (state)
            S_FETCH: begin
                imem_req  = !reset;
                imem_addr = pc;
            end
            S_DECODE: begin
                rf_raddr1 = REGBITS'(ir[11:8]);
                rf_raddr2 = REGBITS'(ir[3:0]);
            end
            S_EXECUTE: begin
                alu_a  = ex_a;
                alu_b  = ex_b;
                alu_op = ex_code;
            end
            S_WRITEBACK: begin
                rf_we    = ex_write && !reset;
                rf_waddr = REGBITS'(ir[11:8]);
                rf_wdata = res_hold;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: behavioural ALU and register file around the DUT, directed and random programs.
module tb_alu_sequencer;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic [3:0]  rf_raddr1, rf_raddr2;
    logic [15:0] rf_rdata1, rf_rdata2;
    logic [15:0] alu_a, alu_b;
    logic [3:0]  alu_op;
    logic [15:0] alu_result;
    logic [4:0]  alu_flags;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [15:0] rf_wdata;
    logic [4:0]  psr;
    logic [15:0] pc;
    logic        illegal;

    logic [15:0] rf  [16];
    logic [15:0] mrf [16];
    logic [15:0] m_pc;
    logic [4:0]  m_psr;
    int          n_checks;
    int          n_fail;

    // Instruction-set tables: ALU code per ext (register form) or per opcode (immediate form), -1 = undecodable.
    int          reg_code [16];
    int          imm_code [16];
    logic [3:0]  ext_pick [8];
    logic [3:0]  op_pick  [7];

    alu_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .rf_raddr1  (rf_raddr1),
        .rf_raddr2  (rf_raddr2),
        .rf_rdata1  (rf_rdata1),
        .rf_rdata2  (rf_rdata2),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .alu_flags  (alu_flags),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .psr        (psr),
        .pc         (pc),
        .illegal    (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Environment ALU: returns {L,C,Z,N,F, result}; every op reports all five flags.
    function automatic logic [20:0] alu_model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        logic [15:0] r;
        logic c, f;
        s = '0; r = '0; c = 1'b0; f = 1'b0;
        case (op)
            4'd0, 4'd1, 4'd2, 4'd3: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[15:0];
                c = s[16];
                f = (a[15] == b[15]) && (r[15] != a[15]);
            end
            4'd5, 4'd6, 4'd7, 4'd8: begin
                s = {1'b0, a} - {1'b0, b};
                r = s[15:0];
                c = s[16];
                f = (a[15] != b[15]) && (r[15] != a[15]);
            end
            4'd4:         r = 16'(a * b);
            4'd9, 4'd10:  r = a & b;
            4'd11, 4'd12: r = a | b;
            4'd13, 4'd14: r = a ^ b;
            default:      r = '0;
        endcase
        return {(b > a), c, (a == b), ($signed(b) > $signed(a)), f, r};
    endfunction

    assign {alu_flags, alu_result} = alu_model(alu_op, alu_a, alu_b);
    assign rf_rdata1 = rf[rf_raddr1];
    assign rf_rdata2 = rf[rf_raddr2];

    function automatic bit cond_true(input logic [3:0] c, input logic [4:0] p);
        bit l, cy, z, n, f;
        l = p[4]; cy = p[3]; z = p[2]; n = p[1]; f = p[0];
        case (c)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return cy;
            4'd3:  return !cy;
            4'd4:  return l;
            4'd5:  return !l;
            4'd6:  return n;
            4'd7:  return !n;
            4'd8:  return f;
            4'd9:  return !f;
            4'd10: return !l && !z;
            4'd11: return l || z;
            4'd12: return !n && !z;
            4'd13: return n || z;
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_reg(input logic [3:0] idx, input logic [15:0] val);
        rf[idx]  = val;
        mrf[idx] = val;
    endtask

    // Runs one instruction from the FETCH state, checking each phase against the model.
    task automatic apply_stimulus(input logic [15:0] instr, input int wait_cycles);
        logic [3:0]  op, rd, ext, rs, exp_op;
        logic [15:0] sx, zx, a, b, new_pc;
        logic [20:0] alu_out;
        logic [4:0]  mask, new_psr;
        int          code;
        bit          is_branch, bad, write;

        op = instr[15:12]; rd = instr[11:8]; ext = instr[7:4]; rs = instr[3:0];
        sx = {{8{instr[7]}}, instr[7:0]};
        zx = {8'h00, instr[7:0]};
        is_branch = (op == 4'hC);
        code = -1; a = '0; b = '0;
        if (op == 4'h0) begin
            code = reg_code[ext];
            a = mrf[rd];
            b = mrf[rs];
        end else if (!is_branch) begin
            code = imm_code[op];
            a = (code == 1 || code == 6 || code == 8) ? sx : zx;
            b = mrf[rd];
        end
        bad = !is_branch && (code < 0);
        if (code < 0) begin a = '0; b = '0; end
        exp_op  = (code < 0) ? 4'd0 : 4'(code);
        alu_out = alu_model(exp_op, a, b);
        write   = (code >= 0) && (code != 7) && (code != 8);
        case (code)
            0, 1, 5, 6: mask = 5'b01001;
            2, 3:       mask = 5'b01000;
            7, 8:       mask = 5'b10110;
            default:    mask = 5'b00000;
        endcase
        new_psr = (m_psr & ~mask) | (alu_out[20:16] & mask);
        new_pc  = (is_branch && cond_true(rd, m_psr)) ? m_pc + sx : m_pc + 16'd1;

        check_output("fetch_req", 32'(imem_req), 32'd1);
        check_output("fetch_addr", 32'(imem_addr), 32'(m_pc));
        for (int i = 0; i < wait_cycles; i++) begin
            imem_ack = 1'b0;
            step();
            check_output("wait_req", 32'(imem_req), 32'd1);
            check_output("wait_addr", 32'(imem_addr), 32'(m_pc));
            check_output("wait_we", 32'(rf_we), 32'd0);
        end
        imem_ack = 1'b1;
        imem_rdata = instr;
        step();
        imem_ack = 1'b0;
        imem_rdata = 16'($urandom);
        check_output("dec_req", 32'(imem_req), 32'd0);
        check_output("dec_raddr1", 32'(rf_raddr1), 32'(rd));
        check_output("dec_raddr2", 32'(rf_raddr2), 32'(rs));
        step();
        check_output("ex_op", 32'(alu_op), 32'(exp_op));
        check_output("ex_a", 32'(alu_a), 32'(a));
        check_output("ex_b", 32'(alu_b), 32'(b));
        check_output("ex_illegal", 32'(illegal), 32'(bad));
        check_output("ex_we", 32'(rf_we), 32'd0);
        step();
        check_output("wb_we", 32'(rf_we), 32'(write));
        check_output("wb_illegal", 32'(illegal), 32'd0);
        if (write) begin
            check_output("wb_waddr", 32'(rf_waddr), 32'(rd));
            check_output("wb_wdata", 32'(rf_wdata), 32'(alu_out[15:0]));
            mrf[rd] = alu_out[15:0];
        end
        if (rf_we) rf[rf_waddr] = rf_wdata;
        step();
        m_pc  = new_pc;
        m_psr = new_psr;
        check_output("next_req", 32'(imem_req), 32'd1);
        check_output("pc", 32'(pc), 32'(m_pc));
        check_output("psr", 32'(psr), 32'(m_psr));
    endtask

    task automatic reset_during_execute(input logic [15:0] instr);
        imem_ack = 1'b1;
        imem_rdata = instr;
        step();
        imem_ack = 1'b0;
        step();
        check_output("rst_ex_we", 32'(rf_we), 32'd0);
        reset = 1'b1;
        step();
        check_output("rst_pc", 32'(pc), 32'd0);
        check_output("rst_psr", 32'(psr), 32'd0);
        check_output("rst_req", 32'(imem_req), 32'd0);
        check_output("rst_we", 32'(rf_we), 32'd0);
        check_output("rst_illegal", 32'(illegal), 32'd0);
        reset = 1'b0;
        #1;
        check_output("rst_fetch_req", 32'(imem_req), 32'd1);
        check_output("rst_fetch_addr", 32'(imem_addr), 32'd0);
        m_pc  = '0;
        m_psr = '0;
    endtask

    function automatic logic [15:0] random_instr();
        int          sel;
        logic [15:0] w;
        sel = $urandom_range(0, 9);
        w   = 16'($urandom);
        if (sel < 4) begin
            w[15:12] = 4'h0;
            if (sel != 0) w[7:4] = ext_pick[$urandom_range(0, 7)];
        end else if (sel < 7) begin
            w[15:12] = op_pick[$urandom_range(0, 6)];
        end else if (sel < 9) begin
            w[15:12] = 4'hC;
        end
        return w;
    endfunction

    initial begin
        reg_code = '{-1, 9, 11, 13, -1, 0, 2, -1, -1, 5, -1, 7, -1, -1, 4, -1};
        imm_code = '{-1, 10, 12, 14, -1, 1, 3, -1, -1, 6, -1, 8, -1, -1, -1, -1};
        ext_pick = '{4'd1, 4'd2, 4'd3, 4'd5, 4'd6, 4'd9, 4'd11, 4'd14};
        op_pick  = '{4'd1, 4'd2, 4'd3, 4'd5, 4'd6, 4'd9, 4'd11};
        n_checks = 0;
        n_fail   = 0;
        reset      = 1'b1;
        imem_ack   = 1'b0;
        imem_rdata = '0;
        for (int i = 0; i < 16; i++) set_reg(4'(i), 16'($urandom));
        m_pc  = '0;
        m_psr = '0;

        repeat (3) @(negedge clk);
        $display("[TB] reset state");
        check_output("reset_pc", 32'(pc), 32'd0);
        check_output("reset_psr", 32'(psr), 32'd0);
        check_output("reset_req", 32'(imem_req), 32'd0);
        check_output("reset_we", 32'(rf_we), 32'd0);
        check_output("reset_illegal", 32'(illegal), 32'd0);
        reset = 1'b0;
        #1;

        $display("[TB] directed programs");
        set_reg(4'd1, 16'd3);
        set_reg(4'd2, 16'd4);
        apply_stimulus(16'h0152, 0);
        check_output("add_r1", 32'(mrf[1]), 32'h7);
        set_reg(4'd1, 16'h8000);
        apply_stimulus(16'h51FF, 0);
        check_output("addi_r1", 32'(rf[1]), 32'h7FFF);
        check_output("addi_psr", 32'(psr), 32'b01001);
        apply_stimulus(16'h0332, 3);
        apply_stimulus(16'h24A5, 0);
        set_reg(4'd5, 16'h1234);
        set_reg(4'd6, 16'h1234);
        apply_stimulus(16'h05B6, 0);
        apply_stimulus(16'hC004, 0);
        check_output("beq_taken_pc", 32'(pc), 32'd9);
        set_reg(4'd6, 16'h4321);
        apply_stimulus(16'h05B6, 1);
        apply_stimulus(16'hC004, 0);
        check_output("beq_not_taken_pc", 32'(pc), 32'd11);
        apply_stimulus(16'hF000, 0);
        reset_during_execute(16'h0152);
        apply_stimulus(16'hCEFF, 0);
        check_output("buc_wrap_pc", 32'(pc), 32'hFFFF);
        apply_stimulus(16'hCF05, 2);
        check_output("never_wrap_pc", 32'(pc), 32'h0);

        $display("[TB] random programs");
        for (int k = 0; k < 64; k++) begin
            if (k % 5 == 0) set_reg(4'($urandom_range(0, 15)), 16'($urandom_range(0, 3)));
            if (k % 7 == 0) set_reg(4'($urandom_range(0, 15)), 16'($urandom));
            apply_stimulus(random_instr(), $urandom_range(0, 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
